// File: rtl/dm_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dm_arb_pkg;

   // Arbiter FSM: IDLE arbitrates, BURST streams DMA beats.
   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } stateT;

   // Identifies which requester owned a DM slot.
   typedef enum logic {
      OWN_C = 1'b0,
      OWN_D = 1'b1
   } ownerT;

   // DMA beats always write the full word.
   localparam logic [3:0] BE_ALL = 4'hF;

   // Byte-lane merge: lane i takes the new byte when be[i] is set, else keeps the old byte.
   function automatic logic [31:0] be_merge(input logic [31:0] oldWord,
                                            input logic [31:0] newWord,
                                            input logic [3:0]  be);
      logic [31:0] result;
      result = oldWord;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            result[8*i +: 8] = newWord[8*i +: 8];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/dm_be_merge.sv
// Combinational byte-lane merge of new write data into the current DM word.
module dm_be_merge
   import dm_arb_pkg::*;
(
   input  logic [31:0] oldWord,
   input  logic [31:0] newWord,
   input  logic [3:0]  be,
   output logic [31:0] merged
);

   // One 2:1 mux per byte lane.
   always_comb begin
      merged = be_merge(oldWord, newWord, be);
   end

endmodule

// File: rtl/dm_arbiter.sv
// Arbiter sharing the single-port data memory between the CPU MEM stage
// (single-beat, stall based) and a DMA/loader (word bursts).
//
// Request/grant handshake: a requester raises req and keeps its request
// fields stable until it sees gnt; gnt is combinational and means the access
// is performed in this very cycle (a write lands in the DM at the next clock
// edge, CPU read data is on c_rdata now, DMA read data appears on d_rdata with
// d_rvalid one cycle later). d_wdata is consumed on every cycle with d_gnt.
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int HOLD_MAX = 4,
   parameter int LEN_W    = 4
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             c_req,
   input  logic             c_we,
   input  logic [31:0]      c_addr,
   input  logic [3:0]       c_be,
   input  logic [31:0]      c_wdata,
   input  logic [31:0]      c_pc,
   output logic             c_gnt,
   output logic [31:0]      c_rdata,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [31:0]      d_addr,
   input  logic [LEN_W-1:0] d_len,
   input  logic [31:0]      d_wdata,
   output logic             d_gnt,
   output logic             d_rvalid,
   output logic [31:0]      d_rdata,
   output logic             d_done,
   output logic             dm_wen,
   output logic [31:0]      dm_addr,
   output logic [31:0]      dm_din,
   input  logic [31:0]      dm_dout,
   output logic [31:0]      dm_pc,
   output logic             dbgState
);

   localparam int HOLD_W = $clog2(HOLD_MAX + 1);
   localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(HOLD_MAX);

   stateT             state, stateNext;
   ownerT             rrLast, rrLastNext;
   logic [LEN_W-1:0]  beat, beatNext;
   logic [HOLD_W-1:0] hold, holdNext;
   logic              burstWe, burstWeNext;
   logic [31:0]       burstBase, burstBaseNext;
   logic [LEN_W-1:0]  burstLen, burstLenNext;

   logic              cSlot;
   logic              dSlot;
   logic              dSlotWe;
   logic [31:0]       dSlotAddr;
   logic              lastBeat;

   logic [3:0]        mergeBe;
   logic [31:0]       mergeNew;
   logic [31:0]       mergedWord;

   logic              dRvalidQ;
   logic [31:0]       dRdataQ;
   logic              dDoneQ;

   // FSM and burst bookkeeping registers; reset aborts any burst in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rrLast    <= OWN_D;
         beat      <= '0;
         hold      <= '0;
         burstWe   <= 1'b0;
         burstBase <= '0;
         burstLen  <= '0;
      end else begin
         state     <= stateNext;
         rrLast    <= rrLastNext;
         beat      <= beatNext;
         hold      <= holdNext;
         burstWe   <= burstWeNext;
         burstBase <= burstBaseNext;
         burstLen  <= burstLenNext;
      end
   end

   // Slot decision and next-state: who owns the DM this cycle and how the burst advances.
   always_comb begin
      stateNext     = state;
      rrLastNext    = rrLast;
      beatNext      = beat;
      holdNext      = hold;
      burstWeNext   = burstWe;
      burstBaseNext = burstBase;
      burstLenNext  = burstLen;
      cSlot         = 1'b0;
      dSlot         = 1'b0;
      dSlotWe       = 1'b0;
      dSlotAddr     = '0;
      lastBeat      = 1'b0;
      if (!reset) begin
         case (state)
            IDLE: begin
               // On a tie the owner not served last time wins.
               if (c_req && (!d_req || rrLast == OWN_D)) begin
                  cSlot      = 1'b1;
                  rrLastNext = OWN_C;
               end else if (d_req) begin
                  dSlot         = 1'b1;
                  dSlotWe       = d_we;
                  dSlotAddr     = d_addr;
                  burstWeNext   = d_we;
                  burstBaseNext = d_addr;
                  burstLenNext  = d_len;
                  rrLastNext    = OWN_D;
                  if (d_len == '0) begin
                     lastBeat = 1'b1;
                  end else begin
                     beatNext  = LEN_W'(1);
                     holdNext  = HOLD_W'(1);
                     stateNext = BURST;
                  end
               end
            end
            BURST: begin
               // A waiting CPU steals one slot after HOLD_MAX back-to-back beats.
               if (c_req && hold == HOLD_LIMIT) begin
                  cSlot    = 1'b1;
                  holdNext = '0;
               end else begin
                  dSlot     = 1'b1;
                  dSlotWe   = burstWe;
                  dSlotAddr = burstBase + {{(30-LEN_W){1'b0}}, beat, 2'b00};
                  holdNext  = (hold == HOLD_LIMIT) ? hold : hold + HOLD_W'(1);
                  if (beat == burstLen) begin
                     lastBeat   = 1'b1;
                     beatNext   = '0;
                     holdNext   = '0;
                     rrLastNext = OWN_D;
                     stateNext  = IDLE;
                  end else begin
                     beatNext = beat + LEN_W'(1);
                  end
               end
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   // Merge source: CPU lanes on a CPU slot, full word on a DMA slot.
   always_comb begin
      mergeBe  = cSlot ? c_be : BE_ALL;
      mergeNew = cSlot ? c_wdata : d_wdata;
   end

   dm_be_merge uMerge (
      .oldWord (dm_dout),
      .newWord (mergeNew),
      .be      (mergeBe),
      .merged  (mergedWord)
   );

   // DM port and requester-facing outputs, all zero when nobody owns the slot.
   always_comb begin
      c_gnt   = cSlot;
      d_gnt   = dSlot;
      c_rdata = cSlot ? dm_dout : '0;
      dm_pc   = cSlot ? c_pc : '0;
      dm_addr = '0;
      dm_wen  = 1'b0;
      dm_din  = '0;
      if (cSlot) begin
         dm_addr = c_addr;
         dm_wen  = c_we && (c_be != 4'h0);
         dm_din  = mergedWord;
      end else if (dSlot) begin
         dm_addr = dSlotAddr;
         dm_wen  = dSlotWe;
         dm_din  = mergedWord;
      end
   end

   // Registered DMA read return and end-of-burst pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         dRvalidQ <= 1'b0;
         dRdataQ  <= '0;
         dDoneQ   <= 1'b0;
      end else begin
         dRvalidQ <= dSlot && !dSlotWe;
         if (dSlot && !dSlotWe) begin
            dRdataQ <= dm_dout;
         end
         dDoneQ <= lastBeat;
      end
   end

   assign d_rvalid = dRvalidQ;
   assign d_rdata  = dRdataQ;
   assign d_done   = dDoneQ;
   assign dbgState = state;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed vector table, hand-written burst sequences,
// then randomized traffic checked against a behavioural model.
module tb_dm_arbiter;

   localparam int HOLD_MAX = 4;
   localparam int LEN_W    = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        c_req, c_we;
   logic [31:0] c_addr, c_wdata, c_pc;
   logic [3:0]  c_be;
   logic        c_gnt;
   logic [31:0] c_rdata;
   logic        d_req, d_we;
   logic [31:0] d_addr, d_wdata;
   logic [3:0]  d_len;
   logic        d_gnt, d_rvalid, d_done;
   logic [31:0] d_rdata;
   logic        dm_wen;
   logic [31:0] dm_addr, dm_din, dm_dout, dm_pc;
   logic        dbgState;

   // Data memory seen by the DUT, and the reference copy kept by the model.
   logic [31:0] mem    [1024];
   logic [31:0] refMem [1024];

   assign dm_dout = mem[dm_addr[11:2]];

   dm_arbiter #(.HOLD_MAX(HOLD_MAX), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_be(c_be),
      .c_wdata(c_wdata), .c_pc(c_pc), .c_gnt(c_gnt), .c_rdata(c_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len),
      .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .d_done(d_done), .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_din(dm_din),
      .dm_dout(dm_dout), .dm_pc(dm_pc), .dbgState(dbgState)
   );

   // Clock
   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   // Scoreboard of DMA read data still to come back.
   logic [31:0] exp_q[$];

   // Behavioural model state.
   bit          mActive;
   logic [31:0] mAddrQ[$];
   bit          mWe;
   int          mRun;
   bit          mLastD;
   bit          expRvalid, expDone;

   // Snapshot of combinational outputs in the current cycle.
   logic        obsCGnt, obsDGnt, obsWen;
   logic [31:0] obsAddr, obsDin, obsCRdata, obsPc;

   int          doneCount, rvalidCount;
   logic [31:0] rdataLog[$];

   typedef struct {
      bit          rst;
      bit          cReq, cWe;
      logic [31:0] cAddr;
      logic [3:0]  cBe;
      logic [31:0] cWdata;
      bit          dReq, dWe;
      logic [31:0] dAddr;
      logic [3:0]  dLen;
      bit          eCGnt, eDGnt, eWen;
      logic [31:0] eDin, eCRdata;
   } vecT;

   vecT vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   function automatic vecT mkVec(bit rst, bit cReq, bit cWe, logic [31:0] cAddr, logic [3:0] cBe,
                                 logic [31:0] cWdata, bit dReq, bit dWe, logic [31:0] dAddr,
                                 logic [3:0] dLen, bit eCGnt, bit eDGnt, bit eWen,
                                 logic [31:0] eDin, logic [31:0] eCRdata);
      vecT v;
      v.rst = rst; v.cReq = cReq; v.cWe = cWe; v.cAddr = cAddr; v.cBe = cBe; v.cWdata = cWdata;
      v.dReq = dReq; v.dWe = dWe; v.dAddr = dAddr; v.dLen = dLen;
      v.eCGnt = eCGnt; v.eDGnt = eDGnt; v.eWen = eWen; v.eDin = eDin; v.eCRdata = eCRdata;
      return v;
   endfunction

   // Expected behaviour of one cycle, derived from the arbitration rules.
   task automatic modelCycle();
      bit          cpu, dma, we;
      logic [31:0] addr, din, word;
      cpu = 1'b0; dma = 1'b0; we = 1'b0; addr = '0; din = '0; word = '0;
      expRvalid = 1'b0;
      expDone   = 1'b0;
      if (reset) begin
         mActive = 1'b0; mAddrQ.delete(); mRun = 0; mLastD = 1'b1; exp_q.delete();
      end else if (!mActive) begin
         if (c_req && (!d_req || mLastD)) begin
            cpu = 1'b1;
            mLastD = 1'b0;
         end else if (d_req) begin
            dma = 1'b1;
            mWe = d_we;
            mAddrQ.delete();
            for (int i = 0; i <= int'(d_len); i++) mAddrQ.push_back(d_addr + 32'(4 * i));
            mActive = 1'b1;
            mRun = 0;
            mLastD = 1'b1;
         end
      end else if (c_req && mRun >= HOLD_MAX) begin
         cpu = 1'b1;
      end else begin
         dma = 1'b1;
      end

      if (cpu) begin
         word = refMem[c_addr[11:2]];
         we   = c_we && (c_be != 4'h0);
         din  = word;
         for (int b = 0; b < 4; b++) if (c_be[b]) din[8*b +: 8] = c_wdata[8*b +: 8];
         chk("cpu_c_gnt", {31'b0, obsCGnt}, 32'd1);
         chk("cpu_d_gnt", {31'b0, obsDGnt}, 32'd0);
         chk("cpu_dm_addr", obsAddr, c_addr);
         chk("cpu_dm_pc", obsPc, c_pc);
         chk("cpu_c_rdata", obsCRdata, word);
         chk("cpu_dm_wen", {31'b0, obsWen}, {31'b0, we});
         if (we) begin
            chk("cpu_dm_din", obsDin, din);
            refMem[c_addr[11:2]] = din;
         end
         if (mActive) mRun = 0;
      end else if (dma) begin
         addr = mAddrQ.pop_front();
         mRun++;
         chk("dma_d_gnt", {31'b0, obsDGnt}, 32'd1);
         chk("dma_c_gnt", {31'b0, obsCGnt}, 32'd0);
         chk("dma_dm_addr", obsAddr, addr);
         chk("dma_dm_pc", obsPc, 32'd0);
         chk("dma_c_rdata", obsCRdata, 32'd0);
         chk("dma_dm_wen", {31'b0, obsWen}, {31'b0, mWe});
         if (mWe) begin
            chk("dma_dm_din", obsDin, d_wdata);
            refMem[addr[11:2]] = d_wdata;
         end else begin
            exp_q.push_back(refMem[addr[11:2]]);
            expRvalid = 1'b1;
         end
         if (mAddrQ.size() == 0) begin
            mActive = 1'b0; mRun = 0; mLastD = 1'b1; expDone = 1'b1;
         end
      end else begin
         chk("idle_c_gnt", {31'b0, obsCGnt}, 32'd0);
         chk("idle_d_gnt", {31'b0, obsDGnt}, 32'd0);
         chk("idle_dm_wen", {31'b0, obsWen}, 32'd0);
         chk("idle_dm_addr", obsAddr, 32'd0);
         chk("idle_c_rdata", obsCRdata, 32'd0);
         chk("idle_dm_pc", obsPc, 32'd0);
      end
   endtask

   // One clock cycle with inputs already applied: check comb outputs, clock, check registered outputs.
   task automatic cycle();
      #2;
      obsCGnt = c_gnt; obsDGnt = d_gnt; obsWen = dm_wen; obsAddr = dm_addr;
      obsDin = dm_din; obsCRdata = c_rdata; obsPc = dm_pc;
      modelCycle();
      @(posedge clk);
      #1;
      if (obsWen) mem[obsAddr[11:2]] = obsDin;
      chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, expRvalid});
      if (expRvalid) chk("d_rdata", d_rdata, exp_q.pop_front());
      chk("d_done", {31'b0, d_done}, {31'b0, expDone});
      if (d_done) doneCount++;
      if (d_rvalid) begin
         rvalidCount++;
         rdataLog.push_back(d_rdata);
      end
   endtask

   task automatic idleInputs();
      c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_be = '0; c_wdata = '0; c_pc = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_len = '0; d_wdata = '0;
   endtask

   initial begin
      logic [8:0]  gntPat;
      int          beatIdx, doneBefore, rvBefore, firstRv, wenSeen, gntSeen;
      logic [31:0] saved;

      reset = 1'b1;
      idleInputs();
      doneCount = 0; rvalidCount = 0;
      mActive = 1'b0; mRun = 0; mLastD = 1'b1; mWe = 1'b0;
      for (int i = 0; i < 1024; i++) begin
         mem[i] = $urandom;
         refMem[i] = mem[i];
      end
      mem[4] = 32'h0;          refMem[4] = 32'h0;
      mem[8] = 32'hAABBCCDD;   refMem[8] = 32'hAABBCCDD;
      for (int i = 0; i < 4; i++) begin
         mem[64 + i] = 32'hC0DE0000 + 32'(i);
         refMem[64 + i] = mem[64 + i];
      end

      // Reset: all outputs zero
      cycle();
      cycle();
      chk("reset_dbg_state", {31'b0, dbgState}, 32'd0);
      reset = 1'b0;

      // Directed vector table
      vecs[0] = mkVec(1'b0, 1'b1, 1'b1, 32'h10, 4'hF, 32'h12345678, 1'b0, 1'b0, 32'h0, 4'h0,
                      1'b1, 1'b0, 1'b1, 32'h12345678, 32'h00000000);
      vecs[1] = mkVec(1'b0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0,
                      1'b1, 1'b0, 1'b0, 32'h0, 32'h12345678);
      vecs[2] = mkVec(1'b0, 1'b1, 1'b1, 32'h20, 4'b0010, 32'h00001100, 1'b0, 1'b0, 32'h0, 4'h0,
                      1'b1, 1'b0, 1'b1, 32'hAABB11DD, 32'hAABBCCDD);
      vecs[3] = mkVec(1'b0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0,
                      1'b1, 1'b0, 1'b0, 32'h0, 32'hAABB11DD);
      vecs[4] = mkVec(1'b0, 1'b1, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 4'h0,
                      1'b1, 1'b0, 1'b0, 32'h0, 32'hAABB11DD);
      vecs[5] = mkVec(1'b0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0,
                      1'b1, 1'b0, 1'b0, 32'h0, 32'hAABB11DD);
      vecs[6] = mkVec(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0,
                      1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      vecs[7] = mkVec(1'b0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b1, 1'b0, 32'h20, 4'h0,
                      1'b1, 1'b0, 1'b0, 32'h0, 32'h12345678);
      vecs[8] = mkVec(1'b0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b1, 1'b0, 32'h20, 4'h0,
                      1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      vecs[9] = mkVec(1'b0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0,
                      1'b1, 1'b0, 1'b0, 32'h0, 32'h12345678);
      for (int i = 0; i < 10; i++) begin
         reset = vecs[i].rst;
         c_req = vecs[i].cReq; c_we = vecs[i].cWe; c_addr = vecs[i].cAddr; c_be = vecs[i].cBe;
         c_wdata = vecs[i].cWdata; c_pc = 32'h400 + 32'(4 * i);
         d_req = vecs[i].dReq; d_we = vecs[i].dWe; d_addr = vecs[i].dAddr; d_len = vecs[i].dLen;
         d_wdata = 32'h0;
         cycle();
         chk($sformatf("vec%0d_c_gnt", i), {31'b0, obsCGnt}, {31'b0, vecs[i].eCGnt});
         chk($sformatf("vec%0d_d_gnt", i), {31'b0, obsDGnt}, {31'b0, vecs[i].eDGnt});
         chk($sformatf("vec%0d_dm_wen", i), {31'b0, obsWen}, {31'b0, vecs[i].eWen});
         chk($sformatf("vec%0d_c_rdata", i), obsCRdata, vecs[i].eCRdata);
         if (vecs[i].eWen) chk($sformatf("vec%0d_dm_din", i), obsDin, vecs[i].eDin);
         if (vecs[i].eDGnt) chk($sformatf("vec%0d_d_rdata", i), d_rdata, 32'hAABB11DD);
      end
      reset = 1'b0;
      idleInputs();
      cycle();

      // DMA write burst of 8 at 0xFF8 with the CPU requesting throughout
      doneBefore = doneCount;
      beatIdx = 0;
      gntPat = '0;
      for (int k = 0; k < 9; k++) begin
         d_req = (k == 0); d_we = 1'b1; d_addr = 32'hFF8; d_len = 4'd7;
         d_wdata = 32'hD0000000 + 32'(beatIdx);
         c_req = (k > 0); c_we = 1'b0; c_addr = 32'h40; c_pc = 32'h800 + 32'(k);
         cycle();
         gntPat[8 - k] = obsDGnt;
         if (obsDGnt) beatIdx++;
      end
      chk("burst_gnt_pattern", {23'b0, gntPat}, 32'h1EF);
      c_req = 1'b1; d_req = 1'b0;
      cycle();
      chk("burst_then_cpu", {31'b0, obsCGnt}, 32'd1);
      idleInputs();
      cycle();
      chk("burst_done_once", 32'(doneCount - doneBefore), 32'd1);
      chk("burst_wrap_beat2", mem[0], 32'hD0000002);
      chk("burst_beat0", mem[1022], 32'hD0000000);
      chk("burst_beat7", mem[5], 32'hD0000007);

      // DMA read burst of 4 at 0x100
      rvBefore = rvalidCount;
      rdataLog.delete();
      firstRv = -1;
      for (int k = 0; k < 6; k++) begin
         d_req = (k == 0); d_we = 1'b0; d_addr = 32'h100; d_len = 4'd3;
         cycle();
         if (d_rvalid && firstRv < 0) firstRv = k;
      end
      chk("rd_rvalid_count", 32'(rvalidCount - rvBefore), 32'd4);
      chk("rd_first_latency", 32'(firstRv), 32'd0);
      for (int i = 0; i < 4; i++) begin
         if (i < rdataLog.size()) chk($sformatf("rd_data%0d", i), rdataLog[i], 32'hC0DE0000 + 32'(i));
         else chk($sformatf("rd_data%0d_missing", i), 32'(rdataLog.size()), 32'd4);
      end

      // Reset in the middle of a write burst of 6 at 0x200
      saved = refMem[130];
      doneBefore = doneCount;
      for (int k = 0; k < 3; k++) begin
         d_req = (k == 0); d_we = 1'b1; d_addr = 32'h200; d_len = 4'd5;
         d_wdata = 32'hE0000000 + 32'(k);
         reset = (k == 2);
         cycle();
      end
      reset = 1'b0;
      idleInputs();
      wenSeen = 0; gntSeen = 0;
      for (int k = 0; k < 4; k++) begin
         cycle();
         if (obsWen) wenSeen++;
         if (obsDGnt) gntSeen++;
      end
      chk("abort_no_wen", 32'(wenSeen), 32'd0);
      chk("abort_no_gnt", 32'(gntSeen), 32'd0);
      chk("abort_no_done", 32'(doneCount - doneBefore), 32'd0);
      chk("abort_beat2_untouched", mem[130], saved);
      chk("abort_idle", {31'b0, dbgState}, 32'd0);

      // Randomized traffic against the model
      obsCGnt = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         if (!(c_req && !obsCGnt)) begin
            c_req   = ($urandom_range(0, 99) < 45);
            c_we    = 1'($urandom_range(0, 1));
            c_addr  = $urandom;
            c_be    = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            c_wdata = $urandom;
            c_pc    = $urandom;
         end
         d_req   = ($urandom_range(0, 99) < 15);
         d_we    = 1'($urandom_range(0, 1));
         d_addr  = $urandom;
         d_len   = 4'($urandom_range(0, 15));
         d_wdata = $urandom;
         reset   = ($urandom_range(0, 299) == 0);
         cycle();
      end
      reset = 1'b0;
      idleInputs();
      for (int k = 0; k < 20; k++) cycle();
      chk("final_exp_q_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
